// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit: iterative RV M-extension multiply/divide, one bit per cycle,
// with an optional single-cycle path for zero multiplier, zero divisor and signed overflow.
module riscv_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);
  localparam int CW = $clog2(XLEN) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d, result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d, rd_o_q, rd_o_d;
  logic              neg_q, neg_d, rneg_q, rneg_d, busy_q, busy_d, done_q, done_d;
  logic              s1, s2, div0, ovf, mz, bypass, borrow;
  logic [XLEN-1:0]   mag1, mag2, byp_res, diff, quo, rem, fin_res;
  logic [XLEN:0]     sum, t;
  logic [2*XLEN-1:0] mul_acc, div_acc, step_acc, prod;
  always_comb begin
    s1       = rs1_i[XLEN-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11));
    s2       = rs2_i[XLEN-1] & (op_i[2] ? ~op_i[0] : ~op_i[1]);
    mag1     = s1 ? -rs1_i : rs1_i;
    mag2     = s2 ? -rs2_i : rs2_i;
    div0     = op_i[2] & (rs2_i == '0);
    ovf      = op_i[2] & ~op_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
    mz       = ~op_i[2] & (rs2_i == '0);
    bypass   = EARLY_OUT & (div0 | ovf | mz);
    byp_res  = mz ? '0 : div0 ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);
    // shift-add: the multiplier sits in the low half and is consumed as the product shifts in
    sum      = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    mul_acc  = {sum, acc_q[XLEN-1:1]};
    // restoring divide: remainder in the high half, quotient bits shift into the low half
    t        = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    borrow   = t < {1'b0, b_q};
    diff     = t[XLEN-1:0] - b_q;
    div_acc  = {borrow ? t[XLEN-1:0] : diff, acc_q[XLEN-2:0], ~borrow};
    step_acc = (state_q == MUL) ? mul_acc : div_acc;
    prod     = neg_q ? -step_acc : step_acc;
    quo      = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem      = rneg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
    fin_res  = (state_q == MUL) ? ((op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                                : (op_q[1] ? rem : quo);
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    rd_o_d   = rd_o_q;
    done_d   = 1'b0;
    if (kill_i) state_d = IDLE;
    else case (state_q)
      IDLE: if (start_i) begin
        op_d   = op_i;
        rd_d   = rd_i;
        cnt_d  = '0;
        acc_d  = {{XLEN{1'b0}}, op_i[2] ? mag1 : mag2};
        b_d    = op_i[2] ? mag2 : mag1;
        // a zero divisor keeps the all-ones quotient unsigned, as RISC-V defines it
        neg_d  = (s1 ^ s2) & ~div0;
        rneg_d = s1;
        if (bypass) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = byp_res;
          rd_o_d   = rd_i;
        end else state_d = op_i[2] ? DIV : MUL;
      end
      MUL, DIV: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN-1)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = fin_res;
          rd_o_d   = rd_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
      rd_o_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      rd_o_q   <= rd_o_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign rd_o     = rd_o_q;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// tb_riscv_muldiv_unit: directed vectors; expected results queued at issue and
// compared by an independent monitor whenever done_o pulses.
module tb_riscv_muldiv_unit;
  logic        clk = 1'b0;
  logic        rstn_i = 1'b1;
  logic        start_i = 1'b0;
  logic        kill_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_i = '0;
  logic [31:0] rs2_i = '0;
  logic [4:0]  rd_i = '0;
  logic        busy_o, done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  int          cyc = 0;
  int          pass_cnt = 0;
  int          tot_cnt = 0;
  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          st;
  } exp_t;
  exp_t sb[$];
  localparam logic [2:0] OP_MUL = 3'b000, OP_MULH = 3'b001, OP_MULHSU = 3'b010, OP_MULHU = 3'b011,
                         OP_DIV = 3'b100, OP_DIVU = 3'b101, OP_REM = 3'b110, OP_REMU = 3'b111;
  riscv_muldiv_unit #(.XLEN(32), .EARLY_OUT(1'b1)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .op_i(op_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .rd_i(rd_i), .kill_i(kill_i), .busy_o(busy_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (done_o) begin
      if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("result", {32'd0, result_o}, {32'd0, e.res});
        check("rd", {59'd0, rd_o}, {59'd0, e.rd});
        check("latency", 64'(cyc - e.st), 64'(e.lat));
      end
    end
  end
  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    start_i = 1'b1;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    rd_i    = rd;
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] res, input int lat);
    drive(op, a, b, rd);
    sb.push_back('{res, rd, lat, cyc});
    @(negedge clk);
    start_i = 1'b0;
  endtask
  task automatic wait_done;
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", 64'd0, 64'd1);
      sb.delete();
    end
  endtask
  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic [31:0] res, input int lat);
    @(negedge clk);
    issue(op, a, b, rd, res, lat);
    wait_done();
  endtask
  initial begin
    #1 rstn_i = 1'b0;
    #1;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_result", {32'd0, result_o}, 64'd0);
    check("rst_rd", {59'd0, rd_o}, 64'd0);
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
    issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB, 33);
    wait_done();
    run(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33);
    run(OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 33);
    run(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 33);
    run(OP_MUL,    32'h12345678, 32'h00000010, 5'd5,  32'h23456780, 33);
    run(OP_MULHU,  32'h12345678, 32'h00000010, 5'd6,  32'h00000001, 33);
    run(OP_MULH,   32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 33);
    run(OP_MUL,    32'h0000ABCD, 32'h00000000, 5'd8,  32'h00000000, 1);
    run(OP_MULH,   32'h80000000, 32'h00000000, 5'd9,  32'h00000000, 1);
    run(OP_DIV,    32'hFFFFFFEC, 32'd3,        5'd10, 32'hFFFFFFFA, 33);
    run(OP_REM,    32'hFFFFFFEC, 32'd3,        5'd11, 32'hFFFFFFFE, 33);
    run(OP_DIV,    32'd20,       32'hFFFFFFFD, 5'd12, 32'hFFFFFFFA, 33);
    run(OP_REM,    32'd20,       32'hFFFFFFFD, 5'd13, 32'h00000002, 33);
    run(OP_DIVU,   32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
    run(OP_REMU,   32'd5,        32'd0,        5'd15, 32'h00000005, 1);
    run(OP_DIV,    32'hFFFFFFF9, 32'd0,        5'd16, 32'hFFFFFFFF, 1);
    run(OP_REM,    32'hFFFFFFF9, 32'd0,        5'd17, 32'hFFFFFFF9, 1);
    run(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 1);
    run(OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 1);
    run(OP_DIVU,   32'd100,      32'd7,        5'd20, 32'd14,       33);
    run(OP_REMU,   32'd100,      32'd7,        5'd21, 32'd2,        33);
    // kill an in-flight divide: no done, previous result and tag kept
    @(negedge clk);
    drive(OP_DIV, 32'd1000, 32'd7, 5'd30);
    @(negedge clk);
    start_i = 1'b0;
    check("kill_busy_before", {63'd0, busy_o}, 64'd1);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    check("kill_busy_after", {63'd0, busy_o}, 64'd0);
    check("kill_result_kept", {32'd0, result_o}, 64'd2);
    check("kill_rd_kept", {59'd0, rd_o}, 64'd21);
    repeat (40) @(negedge clk);
    check("kill_result_later", {32'd0, result_o}, 64'd2);
    // kill together with start in IDLE must not accept the start
    drive(OP_MUL, 32'd3, 32'd4, 5'd22);
    kill_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    kill_i = 1'b0;
    check("kill_start_busy", {63'd0, busy_o}, 64'd0);
    repeat (3) @(negedge clk);
    // a second start while busy is ignored
    issue(OP_DIVU, 32'd100, 32'd7, 5'd23, 32'd14, 33);
    repeat (3) @(negedge clk);
    drive(OP_MUL, 32'd2, 32'd3, 5'd24);
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    check("ignored_start_idle", {63'd0, busy_o}, 64'd0);
    check("ignored_start_result", {32'd0, result_o}, 64'd14);
    // asynchronous reset mid-multiply, then a start on the first edge after release
    drive(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd25);
    @(negedge clk);
    start_i = 1'b0;
    repeat (14) @(negedge clk);
    #2 rstn_i = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy_o}, 64'd0);
    check("arst_done", {63'd0, done_o}, 64'd0);
    check("arst_result", {32'd0, result_o}, 64'd0);
    check("arst_rd", {59'd0, rd_o}, 64'd0);
    @(negedge clk);
    rstn_i = 1'b1;
    issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd26, 32'hFFFFFFEB, 33);
    wait_done();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
